// File: rtl/edabk_transmitter_controller.sv
// UART transmitter sequencing FSM: one-entry holding buffer behind a valid/ready handshake,
// and load/shift/clear strobes that frame start + data (LSB first) + stop bits on the datapath.
module edabk_transmitter_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  bclk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  tx_ready,
    input  logic                  tx_abort,
    input  logic                  done,
    output logic                  load,
    output logic                  shift,
    output logic                  clear,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             buf_valid;
    logic             accept;

    // An abort masks ready so a byte offered in the same cycle is dropped, not buffered.
    assign tx_ready = ~buf_valid & ~tx_abort;
    assign accept   = tx_valid & tx_ready;
    assign tx_busy  = (state != IDLE);

    // NOTE: non-blocking assignments in every always_ff so all registers sample pre-edge values.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            tx_data   <= '0;
        end else begin
            if (accept) tx_data <= tx_data_in;
            if (tx_abort)    buf_valid <= 1'b0;
            else if (accept) buf_valid <= 1'b1;
            else if (load)   buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        load        = 1'b0;
        shift       = 1'b0;
        clear       = 1'b0;
        frame_done  = 1'b0;
        if (tx_abort) begin
            clear       = 1'b1;
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        load        = 1'b1;
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    // Shift on the final data done too: the datapath then presents its stop level.
                    if (done) begin
                        shift = 1'b1;
                        if (bit_cnt == LAST_DATA) begin
                            state_nxt   = STOP;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (done) begin
                        if (bit_cnt == LAST_STOP) begin
                            frame_done  = 1'b1;
                            bit_cnt_nxt = '0;
                            if (buf_valid) begin
                                load      = 1'b1;
                                state_nxt = DATA;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Cycles since the last load/done; lets us confirm the datapath bit period matches CLK_DIV.
    localparam int GAP_W = $clog2(CLK_DIV + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CLK_DIV - 1);

    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge bclk or posedge reset) begin
        if (reset)                   gap_cnt <= '0;
        else if (load || done)       gap_cnt <= '0;
        else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
    end

    a_bit_period : assert property (@(posedge bclk) disable iff (reset)
        (tx_busy && done && !tx_abort) |-> (gap_cnt == GAP_LAST));

    a_strobe_excl : assert property (@(posedge bclk) disable iff (reset)
        !(load && shift) && !(clear && (load || shift)));

endmodule

// File: tb/tb_edabk_transmitter_controller.sv
// Bench for edabk_transmitter_controller: datapath responders, a byte scoreboard checked at each
// load and along the serial line, plus hand sequences for abort, reset and two stop bits.
module tb_edabk_transmitter_controller;

    localparam int DW      = 8;
    localparam int CLK_DIV = 16;
    localparam int FRAME1  = (1 + DW + 1) * CLK_DIV;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        bit         b2b;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        bit         b2b;
        int         acc_cyc;
    } sb_t;

    logic          bclk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_valid = 1'b0, tx_valid2 = 1'b0, tx_abort = 1'b0;
    logic [DW-1:0] tx_data_in = '0;
    logic          tx_ready, load, shift, clear, tx_busy, frame_done, done;
    logic [DW-1:0] tx_data;
    logic          tx_ready2, load2, shift2, clear2, tx_busy2, frame_done2, done2;
    logic [DW-1:0] tx_data2;

    always #5 bclk = ~bclk;

    edabk_transmitter_controller #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .STOP_BITS(1)) dut (
        .bclk(bclk), .reset(reset), .tx_valid(tx_valid), .tx_data_in(tx_data_in),
        .tx_ready(tx_ready), .tx_abort(tx_abort), .done(done), .load(load), .shift(shift),
        .clear(clear), .tx_data(tx_data), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    edabk_transmitter_controller #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .STOP_BITS(2)) dut2 (
        .bclk(bclk), .reset(reset), .tx_valid(tx_valid2), .tx_data_in(tx_data_in),
        .tx_ready(tx_ready2), .tx_abort(tx_abort), .done(done2), .load(load2), .shift(shift2),
        .clear(clear2), .tx_data(tx_data2), .tx_busy(tx_busy2), .frame_done(frame_done2)
    );

    // Datapath responders: bit-period counter and shift register driving the serial line.
    logic [DW+2:0] sh1, sh2;
    logic [4:0]    dcnt1, dcnt2;
    logic          line, line2;

    always @(posedge bclk or posedge reset) begin
        if (reset) begin
            sh1 <= '1; dcnt1 <= '0; sh2 <= '1; dcnt2 <= '0;
        end else begin
            dcnt1 <= (load  || dcnt1 == 5'(CLK_DIV - 1)) ? 5'd0 : dcnt1 + 5'd1;
            dcnt2 <= (load2 || dcnt2 == 5'(CLK_DIV - 1)) ? 5'd0 : dcnt2 + 5'd1;
            if (clear)      sh1 <= '1;
            else if (load)  sh1 <= {2'b11, tx_data, 1'b0};
            else if (shift) sh1 <= {1'b1, sh1[DW+2:1]};
            if (clear2)      sh2 <= '1;
            else if (load2)  sh2 <= {2'b11, tx_data2, 1'b0};
            else if (shift2) sh2 <= {1'b1, sh2[DW+2:1]};
        end
    end

    assign done  = (dcnt1 == 5'(CLK_DIV - 1));
    assign done2 = (dcnt2 == 5'(CLK_DIV - 1));
    assign line  = sh1[0];
    assign line2 = sh2[0];

    int  cyc = 0;
    int  n_pass = 0, n_total = 0;
    int  frames_seen = 0;
    sb_t sb[$];

    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] f, input bit b2b);
        bit acc = 1'b0;
        tx_valid   = 1'b1;
        tx_data_in = d;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge bclk);
            if (tx_ready) begin
                sb.push_back('{d, f, b2b, cyc});
                acc = 1'b1;
            end
            step();
        end
        tx_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge bclk);
            ok = !tx_busy && tx_ready && (sb.size() == 0);
            step();
        end
        check("reached_idle", ok, 1);
        repeat (3) step();
    endtask

    task automatic wait_load(output int lc);
        bit ok = 1'b0;
        lc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge bclk);
            if (load) begin
                ok = 1'b1;
                lc = cyc;
            end
            step();
        end
        check("load_seen", ok, 1);
    endtask

    // Scoreboard monitor for the STOP_BITS=1 instance.
    initial begin : monitor
        bit         mon_active = 1'b0, fd_prev = 1'b0, ld_prev = 1'b0;
        int         mon_l = 0, d = 0;
        logic [9:0] mon_frame = '0;
        sb_t        e;
        forever begin
            @(negedge bclk);
            if (reset) begin
                mon_active = 1'b0; fd_prev = 1'b0; ld_prev = 1'b0;
                sb.delete();
            end else begin
                if (fd_prev && !ld_prev) check("busy_after_frame_done", tx_busy, 0);
                if (ld_prev && !tx_abort) check("ready_after_load", tx_ready, 1);
                if (clear) begin
                    mon_active = 1'b0;
                    sb.delete();
                end
                if (frame_done) begin
                    check("frame_done_in_frame", mon_active, 1);
                    if (mon_active) begin
                        check("frame_done_time", cyc - mon_l, FRAME1);
                        frames_seen++;
                    end
                    mon_active = 1'b0;
                end
                if (load) begin
                    check("load_without_shift", shift, 0);
                    check("load_has_queued_byte", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("tx_data_at_load", tx_data, e.data);
                        if (!tx_busy) check("accept_to_load", cyc - e.acc_cyc, 1);
                        if (e.b2b) check("b2b_load_on_frame_done", frame_done, 1);
                        mon_active = 1'b1;
                        mon_l      = cyc;
                        mon_frame  = e.frame;
                    end
                end else if (mon_active) begin
                    d = cyc - mon_l - 1;
                    if (d >= 0 && d % CLK_DIV == CLK_DIV / 2 && d / CLK_DIV < 10)
                        check($sformatf("line_bit%0d", d / CLK_DIV), line, mon_frame[d / CLK_DIV]);
                end
                fd_prev = frame_done;
                ld_prev = load;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vecs[5];
        int   l, l2, n_ld, n_fd, hi, nfd, fdpos, d;
        bit   acc;

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b1};
        vecs[3] = '{8'h81, 10'b1_1000_0001_0, 1'b1};
        vecs[4] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};

        // Reset values
        @(negedge bclk);
        check("rst_load", load, 0);
        check("rst_shift", shift, 0);
        check("rst_clear", clear, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_tx_data", tx_data, 0);
        step();
        step();
        reset = 1'b0;
        repeat (3) step();

        // Table of frames, some sent back-to-back while the previous frame is running
        for (int i = 0; i < 5; i++) begin
            if (!vecs[i].b2b) wait_idle();
            send(vecs[i].data, vecs[i].frame, vecs[i].b2b);
        end
        wait_idle();

        // tx_valid held while the buffer is full
        send(8'h12, 10'b1_0001_0010_0, 1'b0);
        send(8'h34, 10'b1_0011_0100_0, 1'b1);
        tx_valid   = 1'b1;
        tx_data_in = 8'h56;
        for (int i = 0; i < 20; i++) begin
            @(negedge bclk);
            check("held_ready_low", tx_ready, 0);
            check("held_data_kept", tx_data, 8'h34);
            step();
        end
        send(8'h56, 10'b1_0101_0110_0, 1'b1);
        wait_idle();

        // Abort during data bit 3 with the buffer full, plus a same-cycle offer
        send(8'hA5, 10'b1_1010_0101_0, 1'b0);
        wait_load(l);
        send(8'h5A, 10'b1_0101_1010_0, 1'b1);
        while (cyc < l + 70) step();
        tx_abort   = 1'b1;
        tx_valid   = 1'b1;
        tx_data_in = 8'h77;
        @(negedge bclk);
        check("abort_clear", clear, 1);
        check("abort_no_load", load, 0);
        check("abort_no_shift", shift, 0);
        check("abort_ready_low", tx_ready, 0);
        step();
        tx_abort = 1'b0;
        tx_valid = 1'b0;
        @(negedge bclk);
        check("after_abort_busy", tx_busy, 0);
        check("after_abort_ready", tx_ready, 1);
        check("after_abort_clear", clear, 0);
        check("after_abort_data", tx_data, 8'h5A);
        n_ld = 0;
        n_fd = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge bclk);
            n_ld += int'(load);
            n_fd += int'(frame_done);
        end
        check("after_abort_loads", n_ld, 0);
        check("after_abort_frame_done", n_fd, 0);
        step();

        // Asynchronous reset mid-frame, then a fresh frame
        wait_idle();
        send(8'hC3, 10'b1_1100_0011_0, 1'b0);
        wait_load(l);
        send(8'h69, 10'b1_0110_1001_0, 1'b1);
        repeat (40) step();
        check("pre_reset_ready", tx_ready, 0);
        check("pre_reset_busy", tx_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", tx_busy, 0);
        check("midrst_ready", tx_ready, 1);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_strobes", {load, shift, clear, frame_done}, 0);
        step();
        step();
        reset = 1'b0;
        repeat (2) step();
        send(8'h96, 10'b1_1001_0110_0, 1'b0);
        wait_idle();

        // Two stop bits on the second instance
        tx_data_in = 8'h3C;
        tx_valid2  = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge bclk);
            if (tx_ready2) acc = 1'b1;
            step();
        end
        tx_valid2 = 1'b0;
        check("stop2_accept", acc, 1);
        acc = 1'b0;
        l2  = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge bclk);
            if (load2) begin
                acc = 1'b1;
                l2  = cyc;
                check("stop2_tx_data", tx_data2, 8'h3C);
            end
            step();
        end
        check("stop2_load_seen", acc, 1);
        hi    = 0;
        nfd   = 0;
        fdpos = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge bclk);
            d = cyc - l2;
            if (d >= 145 && d <= 176) hi += int'(line2);
            if (d == 144) check("stop2_last_data_bit", line2, 0);
            if (d == 177) check("stop2_busy_after", tx_busy2, 0);
            if (frame_done2) begin
                nfd++;
                fdpos = d;
            end
        end
        check("stop2_frame_done_count", nfd, 1);
        check("stop2_frame_done_time", fdpos, 176);
        check("stop2_high_cycles", hi, 32);

        check("frames_completed", frames_seen, 9);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
